regfile_write_arbiter: RTL and testbench
========================================

// Module: regfile_write_arbiter
// PURPOSE
//  Sole owner of the 32x32 register file write port (RegWrite/rd/write_data).
//  After reset, walks all registers writing zero (clear sequence), then
//  shares the port between two writeback requesters (0 = ALU, 1 = load unit)
//  with round-robin arbitration, a valid/ready handshake and $zero protection.
// PARAMETERS
//  DATA_W           32  write data width
//  ADDR_W           5   register address width
//  NUM_REGS         32  registers cleared by the init walk (<= 2**ADDR_W)
//  ZERO_REG_PROTECT 1   1: writes to address 0 are accepted but never issued
// PORTS
//  clk          in   1       rising-edge clock
//  rst          in   1       reset, synchronous, active-low
//  req0_valid   in   1       requester 0 has a write
//  req0_addr    in   ADDR_W  requester 0 destination register
//  req0_data    in   DATA_W  requester 0 write data
//  req0_ready   out  1       requester 0 write accepted this cycle
//  req1_valid   in   1       requester 1 has a write
//  req1_addr    in   ADDR_W  requester 1 destination register
//  req1_data    in   DATA_W  requester 1 write data
//  req1_ready   out  1       requester 1 write accepted this cycle
//  rf_we        out  1       register file write enable (RegWrite)
//  rf_waddr     out  ADDR_W  register file write address (rd)
//  rf_wdata     out  DATA_W  register file write data
//  init_done    out  1       clear walk finished; arbitration live
// BEHAVIOUR
//  - Reset (rst==0 at posedge): state=CLEAR, clr_cnt=0, rr_ptr=0; rf_we=0,
//    rf_waddr=0, rf_wdata=0, init_done=0. Asserting rst mid-walk or mid-
//    arbitration aborts it; no write issues in the cycle after a reset edge.
//  - CLEAR: each cycle with rst==1 registers rf_we=1, rf_waddr=clr_cnt,
//    rf_wdata=0, clr_cnt++. After address NUM_REGS-1 issues, state=ARB and
//    init_done=1 (registered; first high the cycle after the last clear write).
//    req*_ready=0 throughout CLEAR; requester valids are ignored.
//  - ARB: reqN_ready is combinational from valids + rr_ptr (no reg paths).
//    Only req0 valid -> grant 0; only req1 valid -> grant 1;
//    both valid -> grant rr_ptr, then rr_ptr <= ~granted index.
//    Single-requester grants leave rr_ptr unchanged. Never both ready.
//  - Transfer = valid && ready at posedge. Granted addr/data registered to
//    rf_waddr/rf_wdata with rf_we=1: one-cycle latency, one write per cycle.
//  - ZERO_REG_PROTECT=1 and granted addr==0: ready still 1 (transfer
//    completes, consumes the grant/rr update) but rf_we=0 that cycle.
//  - No transfer in a cycle -> rf_we=0 next cycle; rf_waddr/rf_wdata hold.
//  - Requesters must hold addr/data stable while valid && !ready.
//  - clr_cnt saturates; init_done stays 1 until next reset.
// TESTING
//  1. rst low 2 cycles then high -> rf_we=1 for 32 consecutive cycles, addr
//     0..31, data 0; init_done rises next cycle; ready=0 throughout.
//  2. ARB, req0 {addr=5,data=0xDEADBEEF} alone -> req0_ready=1 same cycle;
//     next cycle rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF.
//  3. Both valid 4 cycles (r0 addr 1, r1 addr 2), rr_ptr=0 -> grants
//     0,1,0,1; rf_waddr 1,2,1,2; the loser's ready stays 0 and it holds.
//  4. req1 valid addr=0 data=0x1234 -> req1_ready=1, next cycle rf_we=0.
//  5. rst low at clear step 10 -> rf_we=0 next cycle; after release walk
//     restarts at addr 0 and issues all 32 writes.
//  6. Requests during CLEAR -> never ready; first grant only after init_done=1.

Source files
------------

// File: rtl/regfile_write_arbiter.sv
// Register file write-port owner: zero-fill walk after reset, then a
// round-robin arbiter between the ALU (req0) and load unit (req1)
// writeback paths, with optional suppression of writes to register 0.
module regfile_write_arbiter #(
    parameter int DATA_W           = 32,
    parameter int ADDR_W           = 5,
    parameter int NUM_REGS         = 32,
    parameter bit ZERO_REG_PROTECT = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              init_done
);

    typedef enum logic {
        CLEAR = 1'b0,
        ARB   = 1'b1
    } state_t;

    // One past the last cleared address; the counter parks here once the walk ends.
    localparam logic [ADDR_W:0] CLR_END = (ADDR_W + 1)'(NUM_REGS);

    state_t            state, state_d;
    logic [ADDR_W:0]   clr_cnt, clr_cnt_d;
    logic              rr_ptr, rr_ptr_d;
    logic              rf_we_d;
    logic [ADDR_W-1:0] rf_waddr_d;
    logic [DATA_W-1:0] rf_wdata_d;
    logic              init_done_d;
    logic              grant0, grant1;
    logic [ADDR_W-1:0] gnt_addr;
    logic [DATA_W-1:0] gnt_data;

    // Grant: on contention rr_ptr picks the winner, otherwise the lone valid requester wins
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (state == ARB) begin
            if (req0_valid && req1_valid) begin
                grant0 = ~rr_ptr;
                grant1 = rr_ptr;
            end else begin
                grant0 = req0_valid;
                grant1 = req1_valid;
            end
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    // Next-state: clear walk, then registered issue of the granted write
    always_comb begin
        state_d     = state;
        clr_cnt_d   = clr_cnt;
        rr_ptr_d    = rr_ptr;
        rf_we_d     = 1'b0;
        rf_waddr_d  = rf_waddr;
        rf_wdata_d  = rf_wdata;
        init_done_d = init_done;
        gnt_addr    = grant1 ? req1_addr : req0_addr;
        gnt_data    = grant1 ? req1_data : req0_data;
        case (state)
            CLEAR: begin
                if (clr_cnt < CLR_END) begin
                    rf_we_d    = 1'b1;
                    rf_waddr_d = clr_cnt[ADDR_W-1:0];
                    rf_wdata_d = '0;
                    clr_cnt_d  = clr_cnt + 1'b1;
                end else begin
                    // Last zero write was issued on the previous edge; go live now.
                    state_d     = ARB;
                    init_done_d = 1'b1;
                end
            end
            ARB: begin
                if (grant0 || grant1) begin
                    rf_waddr_d = gnt_addr;
                    rf_wdata_d = gnt_data;
                    // A write to $zero still completes the handshake but never reaches the file.
                    rf_we_d    = !(ZERO_REG_PROTECT && (gnt_addr == '0));
                    if (req0_valid && req1_valid)
                        rr_ptr_d = ~grant1;
                end
            end
            default: state_d = CLEAR;
        endcase
    end

    // State and output registers; reset aborts any walk or arbitration in progress
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= CLEAR;
            clr_cnt   <= '0;
            rr_ptr    <= 1'b0;
            rf_we     <= 1'b0;
            rf_waddr  <= '0;
            rf_wdata  <= '0;
            init_done <= 1'b0;
        end else begin
            state     <= state_d;
            clr_cnt   <= clr_cnt_d;
            rr_ptr    <= rr_ptr_d;
            rf_we     <= rf_we_d;
            rf_waddr  <= rf_waddr_d;
            rf_wdata  <= rf_wdata_d;
            init_done <= init_done_d;
        end
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: stimulus pushes expected register-file
// writes into a queue, an independent monitor pops them as rf_we appears.
module tb_regfile_write_arbiter;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 32;

    typedef struct packed {
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
    } wr_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              req0_valid, req1_valid;
    logic [ADDR_W-1:0] req0_addr, req1_addr;
    logic [DATA_W-1:0] req0_data, req1_data;
    logic              req0_ready, req1_ready;
    logic              rf_we;
    logic [ADDR_W-1:0] rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
    logic              init_done;

    regfile_write_arbiter #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS), .ZERO_REG_PROTECT(1'b1)
    ) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .init_done(init_done)
    );

    always #5 clk = ~clk;

    int  checks = 0;
    int  errors = 0;
    wr_t exp_q[$];

    // Reference model state
    bit                rst_v;
    bit                prev_rst;
    bit                gen_en;
    int                k;      // rising edges with reset released since the last reset
    bit                pref;   // requester favoured at the next contention
    bit                v0, v1;
    logic [ADDR_W-1:0] a0, a1;
    logic [DATA_W-1:0] d0, d1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [ADDR_W-1:0] rand_addr();
        if ($urandom_range(0, 5) == 0) return '0;
        return ADDR_W'($urandom_range(1, 2**ADDR_W - 1));
    endfunction

    // Monitor: every register-file write must match the oldest expected write
    always @(negedge clk) begin
        if (rf_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_write actual=addr %0d data %0h required=no write", rf_waddr, rf_wdata);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("wr_addr", rf_waddr, e.a);
                chk("wr_data", rf_wdata, e.d);
            end
        end
    end

    // One clock of stimulus plus model update; inputs change 2 time units after the falling edge
    task automatic step();
        bit live, g0, g1;
        @(negedge clk);
        #2;
        if (!prev_rst) chk("we_after_reset", rf_we, 1'b0);
        chk("init_done", init_done, (k > NUM_REGS));
        if (gen_en) begin
            if (!v0 && $urandom_range(0, 2) != 0) begin
                v0 = 1'b1; a0 = rand_addr(); d0 = $urandom;
            end
            if (!v1 && $urandom_range(0, 2) != 0) begin
                v1 = 1'b1; a1 = rand_addr(); d1 = $urandom;
            end
        end
        rst        = rst_v;
        req0_valid = v0; req0_addr = a0; req0_data = d0;
        req1_valid = v1; req1_addr = a1; req1_data = d1;
        #1;
        // The port is shared only once the zero walk (NUM_REGS edges) and one more edge have passed
        live = (k > NUM_REGS);
        g0 = 1'b0;
        g1 = 1'b0;
        if (live) begin
            if (v0 && v1) begin
                g0 = (pref == 1'b0);
                g1 = !g0;
            end else begin
                g0 = v0;
                g1 = v1;
            end
        end
        chk("req0_ready", req0_ready, g0);
        chk("req1_ready", req1_ready, g1);
        if (rst_v) begin
            if (!prev_rst)
                for (int i = 0; i < NUM_REGS; i++) exp_q.push_back('{a: ADDR_W'(i), d: '0});
            if (v0 && v1 && live) pref = g0;
            if (g0) begin
                if (a0 != '0) exp_q.push_back('{a: a0, d: d0});
                v0 = 1'b0;
            end
            if (g1) begin
                if (a1 != '0) exp_q.push_back('{a: a1, d: d1});
                v1 = 1'b0;
            end
            k++;
        end else begin
            k    = 0;
            pref = 1'b0;
            exp_q.delete();
        end
        prev_rst = rst_v;
    endtask

    initial begin
        rst = 1'b0;
        req0_valid = 1'b0; req0_addr = '0; req0_data = '0;
        req1_valid = 1'b0; req1_addr = '0; req1_data = '0;
        rst_v = 1'b0; prev_rst = 1'b1; gen_en = 1'b0; k = 0; pref = 1'b0;
        v0 = 1'b0; v1 = 1'b0; a0 = '0; a1 = '0; d0 = '0; d1 = '0;

        // Reset, then the zero walk with a request already waiting on req0
        repeat (2) step();
        rst_v = 1'b1;
        v0 = 1'b1; a0 = 5'd7; d0 = 32'hCAFE_0007;
        repeat (NUM_REGS + 3) step();

        // Lone req0 write
        v0 = 1'b1; a0 = 5'd5; d0 = 32'hDEAD_BEEF;
        repeat (2) step();

        // Four cycles of contention: grants alternate starting with req0
        for (int i = 0; i < 4; i++) begin
            if (!v0) begin v0 = 1'b1; a0 = 5'd1; d0 = $urandom; end
            if (!v1) begin v1 = 1'b1; a1 = 5'd2; d1 = $urandom; end
            step();
        end
        for (int i = 0; i < 8 && (v0 || v1); i++) step();

        // Write to $zero from req1 is accepted but never issued
        v1 = 1'b1; a1 = '0; d1 = 32'h0000_1234;
        repeat (2) step();

        // Reset in the middle of the walk, then a full restart
        rst_v = 1'b0;
        step();
        rst_v = 1'b1;
        repeat (10) step();
        rst_v = 1'b0;
        repeat (2) step();
        rst_v = 1'b1;
        repeat (NUM_REGS + 2) step();

        // Random traffic from both requesters
        gen_en = 1'b1;
        repeat (400) step();
        gen_en = 1'b0;
        for (int i = 0; i < 10; i++) step();
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
